// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the console arbiter: FSM states, marker bit position
// and the run-cycle counter width.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DUMP    = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam int MARKER_BIT = 7;
    localparam int CYCLE_W    = 64;

endpackage

// File: rtl/uart_arb_fifo.sv
// Per-source byte FIFO: registered occupancy, same-cycle push/pop at any fill level,
// no empty bypass (a pushed byte is readable from the following cycle).
module uart_arb_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic       full,
    output logic       empty,
    output logic [7:0] rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale bytes never escape.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_arb.sv
// Console arbiter: round-robin merge of NUM_SRC byte streams, end-of-sim marker sequencing,
// run-cycle counter and timeout. Define UART_ARB_SRC_TAG_EN to add the out_src grant tag port.
module uart_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC*8-1:0] src_ch,
    output logic [NUM_SRC-1:0]   src_ready,
    input  logic [CYCLE_W-1:0]   max_cycles,
    output logic                 out_valid,
    output logic [7:0]           out_ch,
`ifdef UART_ARB_SRC_TAG_EN
    output logic [IDX_W-1:0]     out_src,
`endif
    output logic                 perf_dump,
    output logic                 sim_done,
    output logic                 sim_timeout,
    output logic [CYCLE_W-1:0]   cycles
);

    logic [NUM_SRC-1:0] full, empty, pop;
    logic [7:0]         rdata [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        uart_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .push    (src_valid[i] && src_ready[i]),
            .pop     (pop[i]),
            .wdata   (src_ch[i*8 +: 8]),
            .full    (full[i]),
            .empty   (empty[i]),
            .rdata   (rdata[i])
        );
    end

    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign src_ready = ~full & {NUM_SRC{reset_n}};

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_ch_q, out_ch_d;
`ifdef UART_ARB_SRC_TAG_EN
    logic [IDX_W-1:0]   out_src_q, out_src_d;
`endif

    logic               grant_found;
    logic [IDX_W-1:0]   grant;
    logic [7:0]         popped;
    logic               timeout_hit;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cycles_d     = cycles_q;
        out_valid_d  = 1'b0;
        out_ch_d     = out_ch_q;
`ifdef UART_ARB_SRC_TAG_EN
        out_src_d    = out_src_q;
`endif
        pop          = '0;
        grant_found  = 1'b0;
        grant        = last_grant_q;

        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!grant_found && !empty[(int'(last_grant_q) + k) % NUM_SRC]) begin
                grant_found = 1'b1;
                grant       = IDX_W'((int'(last_grant_q) + k) % NUM_SRC);
            end
        end
        popped      = rdata[grant];
        timeout_hit = (max_cycles != '0) && (cycles_q >= max_cycles);

        case (state_q)
            RUN: begin
                if (timeout_hit) state_d = TIMEOUT;
                if (grant_found) begin
                    pop[grant]   = 1'b1;
                    last_grant_d = grant;
                    if (popped[MARKER_BIT]) begin
                        state_d = DUMP;
                    end else begin
                        out_valid_d = 1'b1;
                        out_ch_d    = popped;
`ifdef UART_ARB_SRC_TAG_EN
                        out_src_d   = grant;
`endif
                    end
                end
                // The cycle that detects the limit is the exit cycle, so the count freezes at max_cycles.
                if (!timeout_hit && (cycles_q != '1)) cycles_d = cycles_q + CYCLE_W'(1);
            end
            DUMP:    state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            last_grant_q <= IDX_W'(NUM_SRC - 1);
            cycles_q     <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
`ifdef UART_ARB_SRC_TAG_EN
            out_src_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cycles_q     <= cycles_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
`ifdef UART_ARB_SRC_TAG_EN
            out_src_q    <= out_src_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
`ifdef UART_ARB_SRC_TAG_EN
    assign out_src     = out_src_q;
`endif
    assign perf_dump   = (state_q == DUMP);
    assign sim_done    = (state_q == DONE);
    assign sim_timeout = (state_q == TIMEOUT);
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_uart_arb.sv
// Scoreboard bench for uart_arb: directed stimulus pushes expected console bytes into a queue,
// an independent negedge monitor pops and compares every out_valid byte.
module tb_uart_arb;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  src_valid = '0;
    logic [31:0] src_ch = '0;
    logic [3:0]  src_ready;
    logic [63:0] max_cycles = '0;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        perf_dump, sim_done, sim_timeout;
    logic [63:0] cycles;

    uart_arb #(.NUM_SRC(4), .FIFO_DEPTH(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .src_valid   (src_valid),
        .src_ch      (src_ch),
        .src_ready   (src_ready),
        .max_cycles  (max_cycles),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .perf_dump   (perf_dump),
        .sim_done    (sim_done),
        .sim_timeout (sim_timeout),
        .cycles      (cycles)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         perf_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented byte must match the head of the expected queue.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (perf_dump) perf_cnt++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", out_ch);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("out_ch", {56'h0, out_ch}, {56'h0, exp_b});
                    end
                end
            end
        end
    end

    task automatic drive(input logic [3:0] v, input logic [31:0] ch);
        @(negedge clock);
        src_valid = v;
        src_ch    = ch;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst_out_valid"}, out_valid, 0);
        check({tag, "_rst_perf_dump"}, perf_dump, 0);
        check({tag, "_rst_sim_done"}, sim_done, 0);
        check({tag, "_rst_sim_timeout"}, sim_timeout, 0);
        check({tag, "_rst_cycles"}, cycles, 0);
    endtask

    task automatic do_reset(input string tag);
        check({tag, "_pending_bytes"}, exp_q.size(), 0);
        reset_n   = 1'b0;
        src_valid = '0;
        src_ch    = '0;
        #1;
        check_reset_outputs(tag);
        idle(2);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] four_bytes(input int k);
        logic [31:0] ch;
        for (int i = 0; i < 4; i++) ch[i*8 +: 8] = 8'(32'h20 + 16 * i + k);
        return ch;
    endfunction

    initial begin
        int cnt, first, last, pbase;
        logic [63:0] prev_c;
        logic seen;

        // Single source "Hi": 2-cycle latency, one-cycle pulses.
        do_reset("t1");
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        drive(4'b0001, 32'h48);
        drive(4'b0001, 32'h69);
        check("t1_no_early_valid", out_valid, 0);
        drive(4'b0000, 32'h0);
        check("t1_first_valid", out_valid, 1);
        check("t1_first_ch", out_ch, 8'h48);
        @(negedge clock);
        check("t1_second_valid", out_valid, 1);
        check("t1_second_ch", out_ch, 8'h69);
        @(negedge clock);
        check("t1_pulse_end", out_valid, 0);

        // Full contention: 16 bytes, round-robin src0..src3, back to back.
        do_reset("t2");
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(32'h20 + 16 * i + k));
        cnt = 0; first = -1; last = -1;
        fork
            begin
                for (int k = 0; k < 4; k++) drive(4'hF, four_bytes(k));
                drive(4'h0, 32'h0);
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    @(negedge clock);
                    if (out_valid) begin
                        if (first < 0) first = j;
                        last = j;
                        cnt++;
                    end
                end
            end
        join
        check("t2_byte_count", cnt, 16);
        check("t2_contiguous", last - first, 15);

        // Marker on source 2: 0x41 forwarded, marker swallowed, dump pulse then done.
        do_reset("t3");
        pbase = perf_cnt;
        exp_q.push_back(8'h41);
        drive(4'b0100, 32'h0041_0000);
        drive(4'b0100, 32'h0080_0000);
        drive(4'b0000, 32'h0);
        @(negedge clock);
        check("t3_perf_dump_high", perf_dump, 1);
        check("t3_done_not_yet", sim_done, 0);
        @(negedge clock);
        check("t3_perf_dump_low", perf_dump, 0);
        check("t3_done", sim_done, 1);
        drive(4'b0100, 32'h0042_0000);
        drive(4'b0000, 32'h0);
        idle(10);
        check("t3_done_sticky", sim_done, 1);
        check("t3_perf_pulses", perf_cnt - pbase, 1);
        check("t3_no_timeout", sim_timeout, 0);

        // Timeout at 100 cycles, no traffic.
        max_cycles = 64'd100;
        do_reset("t4");
        pbase = perf_cnt;
        seen = 1'b0;
        prev_c = '0;
        for (int j = 0; j < 300 && !seen; j++) begin
            @(negedge clock);
            if (sim_timeout) begin
                seen = 1'b1;
                check("t4_cycles_when_condition_held", prev_c, 100);
            end else begin
                prev_c = cycles;
            end
        end
        check("t4_timeout_seen", seen, 1);
        idle(5);
        check("t4_cycles_frozen", cycles, 100);
        check("t4_timeout_sticky", sim_timeout, 1);
        check("t4_no_dump", perf_cnt - pbase, 0);
        check("t4_not_done", sim_done, 0);

        // max_cycles = 0 disables the timeout.
        max_cycles = 64'd0;
        do_reset("t4b");
        repeat (10000) @(posedge clock);
        @(negedge clock);
        check("t4b_no_timeout", sim_timeout, 0);
        check("t4b_cycles", cycles, 10000);

        // Backpressure: arbitration halted by a marker, source 1 fills to 8 and refuses the 9th.
        do_reset("t5");
        drive(4'b0001, 32'h80);
        drive(4'b0000, 32'h0);
        idle(3);
        check("t5_halted_done", sim_done, 1);
        for (int n = 0; n < 9; n++) begin
            @(negedge clock);
            check($sformatf("t5_ready_before_push%0d", n), src_ready[1], (n < 8) ? 1 : 0);
            src_valid = 4'b0010;
            src_ch    = {16'h0, 8'(32'h60 + n), 8'h0};
        end
        drive(4'b0000, 32'h0);
        check("t5_still_full", src_ready[1], 0);
        check("t5_src0_ready", src_ready[0], 1);

        // Reset mid-stream with FIFOs partly filled.
        do_reset("t6");
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        for (int k = 0; k < 4; k++) drive(4'hF, four_bytes(k));
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        src_valid = '0;
        #1;
        check_reset_outputs("t6_mid");
        check("t6_mid_ready", src_ready, 0);
        check("t6_drained_before_reset", exp_q.size(), 0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(8'h55);
        drive(4'b1000, 32'h5500_0000);
        drive(4'b0000, 32'h0);
        idle(4);
        check("t6_fresh_byte_seen", exp_q.size(), 0);
        check("t6_ready_all", src_ready, 4'hF);

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_arb.md
# uart_arb

Console arbiter and end-of-simulation sequencer for the simulation top. It merges up to `NUM_SRC` independent byte-wide UART transmit streams (one per hart or agent) into a single console stream. Each stream has its own small FIFO, and sources are served round-robin. The block also owns the run-cycle counter, detects the end-of-simulation marker byte, sequences the one-cycle perf-dump pulse and flags a max-cycle timeout.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters, range 1..16
- `FIFO_DEPTH`, 8: entries per source FIFO, power of two, ≥2

Ports:
- `clock`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `src_valid`  in  NUM_SRC  per-source byte valid
- `src_ch`  in  NUM_SRC×8  per-source byte
- `src_ready`  out  NUM_SRC  per-source FIFO not full
- `max_cycles`  in  64  timeout limit; 0 disables the timeout; sampled every cycle
- `out_valid`  out  1  printable byte valid, one-cycle pulse per byte
- `out_ch`  out  8  printable byte, bit 7 always 0
- `perf_dump`  out  1  one-cycle pulse after the marker is consumed
- `sim_done`  out  1  sticky; marker consumed and dump issued
- `sim_timeout`  out  1  sticky; cycle limit reached
- `cycles`  out  64  cycles spent in RUN

## Operation
- Push: the byte on source i is written when `src_valid[i] && src_ready[i]`. Pushing while full is not a protocol error; the byte is simply not accepted.
- Arbitration happens only in the RUN state. Each cycle the arbiter pops at most one entry from a non-empty FIFO.
  - The search starts at `last_grant+1` and wraps around modulo `NUM_SRC`.
  - The reset value of `last_grant` is `NUM_SRC-1`, so source 0 wins first.
- A popped byte with bit 7 = 0 is registered to `out_ch`, and `out_valid` is high for the next cycle.
- A popped byte with bit 7 = 1 is the marker. It is never forwarded, and the FSM moves to DUMP.
- FSM states:
  - RUN: arbitrate and count cycles.
  - DUMP: `perf_dump`=1 for exactly one cycle, then go to DONE.
  - DONE: `sim_done`=1; terminal.
  - TIMEOUT: `sim_timeout`=1; terminal.
- Timeout condition: in RUN, if `max_cycles != 0 && cycles >= max_cycles`, go to TIMEOUT.
- If a marker pop and the timeout condition occur in the same cycle, the marker wins and the next state is DUMP.
- In DUMP, DONE and TIMEOUT, no pops occur. FIFOs keep accepting bytes until full; the remaining contents are held, not flushed.
- `cycles` increments by 1 every RUN cycle. It saturates at 2^64−1 and does not wrap.
- Reset values: all outputs 0; state RUN; FIFOs empty; `cycles` 0; `src_ready` all 1 from the first cycle after reset release.
- Reset asserted mid-operation: immediate return to the reset values. Any in-flight byte and all FIFO contents are discarded.

## Timing
- Push-to-console latency is 2 cycles: FIFO write at edge t, pop and register at edge t+1, `out_valid` visible in the cycle after edge t+1.
- Throughput is one byte per cycle aggregate. Under full contention each source gets 1/`NUM_SRC`.
- The FIFO supports push and pop in the same cycle at any occupancy, including full (pop frees the slot in that same cycle; `src_ready` is computed from the registered count and does not combinationally follow the pop) and empty (no bypass).
- Marker popped at edge t → `perf_dump` high in cycle t+1 → `sim_done` high from cycle t+2 onward.
- The timeout condition is evaluated on the registered `cycles` value; `sim_timeout` rises one cycle after the condition first holds.

## Configuration
- `UART_ARB_SRC_TAG_EN`:
  - Defined: an extra output `out_src` (width $clog2(NUM_SRC), minimum 1) carries the granted source index, registered alongside `out_ch` and 0 at reset.
  - Undefined: the port and its register do not exist.
- All other behaviour is identical with and without the macro.

## Structure
- `uart_arb_pkg` holds:
  - the state enum (`RUN`, `DUMP`, `DONE`, `TIMEOUT`)
  - `MARKER_BIT` = 7
  - `CYCLE_W` = 64
- Sub-module `uart_arb_fifo`: synchronous FIFO of 8-bit entries, parameterised by depth, with `push`, `pop`, `full`, `empty` and a read-data output. It is instantiated `NUM_SRC` times.
- The round-robin picker, FSM and counter live in the top module.

## Test plan
- Single source, reset release then push 'H','i' (0x48, 0x69) on source 0: `out_ch` shows 0x48 then 0x69, each with `out_valid` as a one-cycle pulse, first byte 2 cycles after the push.
- Contention: sources 0–3 each push 4 bytes in the same cycles. Output order is src0, src1, src2, src3, repeated; 16 bytes in 16 consecutive cycles.
- Marker: source 2 pushes 0x41, then 0x80. Output is 0x41 only; `perf_dump` is exactly one cycle; `sim_done` stays 1; bytes pushed later are never output.
- Timeout with `max_cycles`=100 and no pushes: `sim_timeout` rises, `cycles` freezes at 100, `perf_dump` stays 0. Repeat with `max_cycles`=0 for 10,000 cycles: no timeout.
- Backpressure: push 9 bytes into source 1 while a marker from source 0 has halted arbitration. `src_ready[1]` drops after the 8th byte and the 9th is not accepted.
- Reset mid-stream: assert `reset_n`=0 with FIFOs half full. All outputs go to 0 immediately; after release the first byte output is the next newly pushed byte.
